// File: rtl/hough_sweep_sched_pkg.sv
// hough_sweep_sched_pkg: state encodings, sweep/scan limits and widths shared by
// the Hough scheduler, its address stepper, the controller and block_memo.
package hough_sweep_sched_pkg;
   localparam int HS_MSB_POINT = 15;
   localparam int HS_MSB_PHI   = 7;
   localparam int HS_PHI_LAST  = 179;
   localparam int HS_MSB_ADDR  = 15;
   localparam int HS_ADDR_LAST = 46079;
   localparam int HS_CNT_W     = 16;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_VOTE  = 3'd2,
      ST_SCAN  = 3'd3,
      ST_CLEAR = 3'd4,
      ST_DONE  = 3'd5
   } state_t;
   function automatic logic [HS_CNT_W-1:0] sat_inc(input logic [HS_CNT_W-1:0] v);
      return (&v) ? v : v + HS_CNT_W'(1);
   endfunction
endpackage

// File: rtl/hough_sweep_sched_stepper.sv
// hough_sweep_sched_stepper: accumulator address walker for one valid/ready stream;
// advances on each accepted beat and returns to 0 after the terminal address is taken.
module hough_sweep_sched_stepper
   import hough_sweep_sched_pkg::*;
#(
   parameter int MSB_ADDR  = HS_MSB_ADDR,
   parameter int ADDR_LAST = HS_ADDR_LAST
)(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_load,
   input  logic              i_valid,
   input  logic              i_ready,
   output logic [MSB_ADDR:0] o_addr,
   output logic              o_done
);
   logic [MSB_ADDR:0] r_addr;
   logic              w_fire;
   logic              w_last;
   assign w_fire = i_valid & i_ready;
   assign w_last = r_addr == (MSB_ADDR+1)'(ADDR_LAST);
   assign o_done = w_fire & w_last;
   assign o_addr = r_addr;
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n)
         r_addr <= '0;
      else if (i_load || o_done)
         r_addr <= '0;
      else if (w_fire)
         r_addr <= r_addr + (MSB_ADDR+1)'(1);
endmodule

// File: rtl/hough_sweep_sched.sv
// hough_sweep_sched: frame scheduler -- per-point phi sweep of votes, accumulator scan,
// optional accumulator clear (present when HOUGH_SCHED_CLR_EN is defined).
module hough_sweep_sched
   import hough_sweep_sched_pkg::*;
#(
   parameter int MSB_POINT = HS_MSB_POINT,
   parameter int MSB_PHI   = HS_MSB_PHI,
   parameter int PHI_LAST  = HS_PHI_LAST,
   parameter int MSB_ADDR  = HS_MSB_ADDR,
   parameter int ADDR_LAST = HS_ADDR_LAST
)(
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_pt_valid,
   output logic                o_pt_ready,
   input  logic [MSB_POINT:0]  i_pt_x,
   input  logic [MSB_POINT:0]  i_pt_y,
   input  logic                i_pt_last,
   output logic                o_vote_valid,
   input  logic                i_vote_ready,
   output logic [MSB_POINT:0]  o_vote_x,
   output logic [MSB_POINT:0]  o_vote_y,
   output logic [MSB_PHI:0]    o_vote_phi,
   output logic                o_scan_valid,
   input  logic                i_scan_ready,
   output logic [MSB_ADDR:0]   o_scan_addr,
   output logic                o_clr_valid,
   input  logic                i_clr_ready,
   output logic [MSB_ADDR:0]   o_clr_addr,
   output logic                o_busy,
   output logic                o_done,
   output logic [HS_CNT_W-1:0] o_pt_cnt,
   output logic [2:0]          o_state
);
`ifdef HOUGH_SCHED_CLR_EN
   localparam logic CLR_EN = 1'b1;
`else
   localparam logic CLR_EN = 1'b0;
`endif
   state_t              r_state, w_next;
   logic [MSB_POINT:0]  r_x, r_y;
   logic                r_last;
   logic [MSB_PHI:0]    r_phi;
   logic [HS_CNT_W-1:0] r_pt_cnt;
   logic                w_pt_fire, w_vote_fire, w_phi_end, w_sweep_end;
   logic                w_scan_done, w_clr_done, w_clr_valid;
   logic [MSB_ADDR:0]   w_scan_addr, w_clr_addr;
   assign w_pt_fire   = (r_state == ST_FETCH) & i_pt_valid;
   assign w_vote_fire = (r_state == ST_VOTE) & i_vote_ready;
   assign w_phi_end   = r_phi == (MSB_PHI+1)'(PHI_LAST);
   assign w_sweep_end = w_vote_fire & w_phi_end;
   assign w_clr_valid = CLR_EN & (r_state == ST_CLEAR);
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_FETCH;
         ST_FETCH: if (i_pt_valid) w_next = ST_VOTE;
         ST_VOTE:  if (w_sweep_end) w_next = r_last ? ST_SCAN : ST_FETCH;
         ST_SCAN:  if (w_scan_done) w_next = CLR_EN ? ST_CLEAR : ST_DONE;
         ST_CLEAR: if (w_clr_done) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (i_abort) w_next = ST_IDLE;
   end
   // abort freezes every datapath register, so pt_cnt keeps the aborted frame's count
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_last   <= 1'b0;
         r_phi    <= '0;
         r_pt_cnt <= '0;
      end else if (!i_abort) begin
         if (r_state == ST_IDLE && i_start)
            r_pt_cnt <= '0;
         if (w_pt_fire) begin
            r_x      <= i_pt_x;
            r_y      <= i_pt_y;
            r_last   <= i_pt_last;
            r_phi    <= '0;
            r_pt_cnt <= sat_inc(r_pt_cnt);
         end
         if (w_vote_fire && !w_phi_end)
            r_phi <= r_phi + (MSB_PHI+1)'(1);
      end
   hough_sweep_sched_stepper #(.MSB_ADDR(MSB_ADDR), .ADDR_LAST(ADDR_LAST)) u_scan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_sweep_end & r_last & ~i_abort),
      .i_valid   (r_state == ST_SCAN),
      .i_ready   (i_scan_ready & ~i_abort),
      .o_addr    (w_scan_addr),
      .o_done    (w_scan_done)
   );
   hough_sweep_sched_stepper #(.MSB_ADDR(MSB_ADDR), .ADDR_LAST(ADDR_LAST)) u_clr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_scan_done & ~i_abort),
      .i_valid   (w_clr_valid),
      .i_ready   (i_clr_ready & ~i_abort),
      .o_addr    (w_clr_addr),
      .o_done    (w_clr_done)
   );
   assign o_pt_ready   = r_state == ST_FETCH;
   assign o_vote_valid = r_state == ST_VOTE;
   assign o_vote_x     = r_x;
   assign o_vote_y     = r_y;
   assign o_vote_phi   = r_phi;
   assign o_scan_valid = r_state == ST_SCAN;
   assign o_scan_addr  = w_scan_addr;
   assign o_clr_valid  = w_clr_valid;
   assign o_clr_addr   = CLR_EN ? w_clr_addr : '0;
   assign o_busy       = r_state != ST_IDLE;
   assign o_done       = r_state == ST_DONE;
   assign o_pt_cnt     = r_pt_cnt;
   assign o_state      = r_state;
endmodule

// File: tb/tb_hough_sweep_sched.sv
// tb_hough_sweep_sched: directed bench for hough_sweep_sched with a shortened accumulator
// (ADDR_LAST=15); expected clear behaviour follows HOUGH_SCHED_CLR_EN.
module tb_hough_sweep_sched;
   localparam int AL = 15;
`ifdef HOUGH_SCHED_CLR_EN
   localparam int CLR = 1;
`else
   localparam int CLR = 0;
`endif
   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic        pt_valid = 1'b0, pt_last = 1'b0;
   logic        vote_ready = 1'b1, scan_ready = 1'b1, clr_ready = 1'b1;
   logic [15:0] pt_x = '0, pt_y = '0;
   logic        o_pt_ready, o_vote_valid, o_scan_valid, o_clr_valid, o_busy, o_done;
   logic [15:0] o_vote_x, o_vote_y, o_scan_addr, o_clr_addr, o_pt_cnt;
   logic [7:0]  o_vote_phi;
   logic [2:0]  o_state;
   always #5 clk = ~clk;
   hough_sweep_sched #(.ADDR_LAST(AL)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_abort(abort),
      .i_pt_valid(pt_valid), .o_pt_ready(o_pt_ready), .i_pt_x(pt_x), .i_pt_y(pt_y),
      .i_pt_last(pt_last), .o_vote_valid(o_vote_valid), .i_vote_ready(vote_ready),
      .o_vote_x(o_vote_x), .o_vote_y(o_vote_y), .o_vote_phi(o_vote_phi),
      .o_scan_valid(o_scan_valid), .i_scan_ready(scan_ready), .o_scan_addr(o_scan_addr),
      .o_clr_valid(o_clr_valid), .i_clr_ready(clr_ready), .o_clr_addr(o_clr_addr),
      .o_busy(o_busy), .o_done(o_done), .o_pt_cnt(o_pt_cnt), .o_state(o_state)
   );
   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   logic [15:0] px [3];
   logic [15:0] py [3];
   int n_pts = 0, idx = 0;
   logic tog = 1'b0, mon_clr = 1'b0;
   int n_votes, phi_err, xy_err, stall_err, n_scan, n_clr, addr_err, clr_seen;
   int n_done, cyc, last_scan_cyc, done_cyc;
   logic pvv, pvr, psv, psr;
   logic [15:0] ppx, ppy, psa;
   logic [7:0] pphi;
   always @(negedge clk) begin
      if (mon_clr) begin
         n_votes = 0; phi_err = 0; xy_err = 0; stall_err = 0; n_scan = 0; n_clr = 0;
         addr_err = 0; clr_seen = 0; n_done = 0; cyc = 0; last_scan_cyc = 0; done_cyc = 0;
         pvv = 0; pvr = 0; psv = 0; psr = 0;
      end else begin
         cyc++;
         if (o_vote_valid && vote_ready) begin
            if (o_vote_phi !== 8'(n_votes % 180)) phi_err++;
            if (n_votes / 180 >= n_pts || o_vote_x !== px[n_votes / 180] || o_vote_y !== py[n_votes / 180])
               xy_err++;
            n_votes++;
         end
         if (pvv && !pvr && (!o_vote_valid || o_vote_x !== ppx || o_vote_y !== ppy || o_vote_phi !== pphi))
            stall_err++;
         if (psv && !psr && (!o_scan_valid || o_scan_addr !== psa)) stall_err++;
         if (o_scan_valid && scan_ready) begin
            if (o_scan_addr !== 16'(n_scan)) addr_err++;
            if (o_scan_addr == 16'(AL)) last_scan_cyc = cyc;
            n_scan++;
         end
         if (o_clr_valid) clr_seen++;
         if (o_clr_valid && clr_ready) begin
            if (o_clr_addr !== 16'(n_clr)) addr_err++;
            n_clr++;
         end
         if (o_done) begin
            n_done++;
            done_cyc = cyc;
         end
         pvv = o_vote_valid; pvr = vote_ready; ppx = o_vote_x; ppy = o_vote_y; pphi = o_vote_phi;
         psv = o_scan_valid; psr = scan_ready; psa = o_scan_addr;
      end
   end
   task automatic load_pt();
      if (idx < n_pts) begin
         pt_valid = 1'b1; pt_x = px[idx]; pt_y = py[idx]; pt_last = (idx == n_pts - 1);
      end else
         pt_valid = 1'b0;
   endtask
   task automatic step();
      logic acc;
      acc = pt_valid & o_pt_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         idx++;
         load_pt();
      end
      if (tog) begin
         vote_ready = ~vote_ready;
         scan_ready = ~scan_ready;
      end
   endtask
   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int n = 0;
      while (o_state !== s && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(o_state), 32'(s));
   endtask
   task automatic wait_phi(input string tag, input logic [7:0] phi, input logic [15:0] cnt);
      int n = 0;
      while (!(o_state == 3'd2 && o_vote_phi == phi && o_pt_cnt == cnt) && n < 1000) begin
         step();
         n++;
      end
      check(tag, 32'(o_vote_phi), 32'(phi));
   endtask
   task automatic begin_frame();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
      idx = 0;
      load_pt();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      #12;
      check("rst_state", 32'(o_state), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_valids", {o_pt_ready, o_vote_valid, o_scan_valid, o_clr_valid, o_done}, 0);
      check("rst_cnt", 32'(o_pt_cnt), 0);
      reset_n = 1'b1;
      // one point, everything ready
      n_pts = 1; px[0] = 16'd10; py[0] = 16'd20;
      begin_frame();
      check("t1_fetch", 32'(o_state), 1);
      check("t1_pt_ready", 32'(o_pt_ready), 1);
      step();
      check("t1_vote_state", 32'(o_state), 2);
      check("t1_vote_xy", {o_vote_y, o_vote_x}, {16'd20, 16'd10});
      check("t1_phi0", 32'(o_vote_phi), 0);
      check("t1_cnt", 32'(o_pt_cnt), 1);
      wait_state("t1_idle", 3'd0, 600);
      check("t1_votes", n_votes, 180);
      check("t1_phi_seq", phi_err, 0);
      check("t1_xy", xy_err, 0);
      check("t1_scans", n_scan, AL + 1);
      check("t1_clears", n_clr, CLR * (AL + 1));
      check("t1_clr_seen", clr_seen, CLR * (AL + 1));
      check("t1_addr_seq", addr_err, 0);
      check("t1_done", n_done, 1);
      check("t1_done_lat", done_cyc - last_scan_cyc, CLR ? AL + 2 : 1);
      check("t1_cnt_end", 32'(o_pt_cnt), 1);
      // three points with ready toggling every cycle
      n_pts = 3; px[0] = 16'd1; py[0] = 16'd2; px[1] = 16'd3; py[1] = 16'd4; px[2] = 16'd5; py[2] = 16'd6;
      tog = 1'b1;
      begin_frame();
      wait_state("t2_idle", 3'd0, 3000);
      tog = 1'b0; vote_ready = 1'b1; scan_ready = 1'b1;
      check("t2_votes", n_votes, 540);
      check("t2_phi_seq", phi_err, 0);
      check("t2_xy", xy_err, 0);
      check("t2_stall", stall_err, 0);
      check("t2_scans", n_scan, AL + 1);
      check("t2_addr_seq", addr_err, 0);
      check("t2_done", n_done, 1);
      check("t2_cnt", 32'(o_pt_cnt), 3);
      // abort mid-sweep of the second point
      px[0] = 16'd7; py[0] = 16'd8; px[1] = 16'd9; py[1] = 16'd10; px[2] = 16'd11; py[2] = 16'd12;
      begin_frame();
      wait_phi("t3_reach", 8'd90, 16'd2);
      abort = 1'b1;
      step();
      abort = 1'b0; pt_valid = 1'b0;
      check("t3_state", 32'(o_state), 0);
      check("t3_vote_valid", 32'(o_vote_valid), 0);
      check("t3_busy", 32'(o_busy), 0);
      check("t3_cnt_held", 32'(o_pt_cnt), 2);
      step(); step(); step();
      check("t3_no_done", n_done, 0);
      check("t3_still_idle", 32'(o_state), 0);
      // restart works; start during VOTE is ignored
      n_pts = 1; px[0] = 16'd13; py[0] = 16'd14;
      begin_frame();
      wait_phi("t4_reach", 8'd40, 16'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t4_start_ign", 32'(o_state), 2);
      check("t4_phi", 32'(o_vote_phi), 41);
      wait_state("t4_idle", 3'd0, 600);
      check("t4_votes", n_votes, 180);
      check("t4_xy", xy_err, 0);
      check("t4_done", n_done, 1);
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("t4_abort_wins", 32'(o_state), 0);
      step();
      check("t4_idle_hold", 32'(o_state), 0);
      // asynchronous reset mid-scan
      n_pts = 1; px[0] = 16'd1; py[0] = 16'd1;
      begin_frame();
      wait_state("t5_scan", 3'd3, 400);
      for (int n = 0; n < 40 && o_scan_addr != 16'd5; n++) step();
      check("t5_addr", 32'(o_scan_addr), 5);
      #2 reset_n = 1'b0;
      #1;
      check("t5_state", 32'(o_state), 0);
      check("t5_valids", {o_scan_valid, o_vote_valid, o_busy, o_done}, 0);
      check("t5_scan_addr", 32'(o_scan_addr), 0);
      check("t5_cnt", 32'(o_pt_cnt), 0);
      check("t5_vote_xy", {o_vote_y, o_vote_x}, 0);
      #10 reset_n = 1'b1;
      step(); step();
      check("t5_after", 32'(o_state), 0);
      check("t5_no_done", n_done, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
